elevator_call_controller: RTL

- Consumes the one-cycle active-high press pulses produced by the per-floor pushbutton debouncers. Holds them as pending floor calls and serves them with a car state machine that drives current floor, motion and door outputs.
- Sits between the bank of debouncers and the display/LED drivers. It is the receiving end of the debounced-pulse interface.

---
 rtl/elevator_pkg.sv | 12 +
 rtl/elevator_timer.sv | 18 +
 rtl/elevator_call_controller.sv | 109 ++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state/direction types and a width helper for the elevator controller
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
  localparam logic UP = 1'b0;
  localparam logic DOWN = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/elevator_timer.sv
// elevator_timer: loadable down-counter that saturates at zero and flags it
module elevator_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = (cnt == '0);
endmodule

// File: rtl/elevator_call_controller.sv
// elevator_call_controller: latches debounced floor calls and serves them SCAN-style
module elevator_call_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req_pulse,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  arrive_pulse
);
  localparam int TW = clog2((TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES);
  localparam logic [TW-1:0] T_TRAVEL = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] T_DOOR = TW'(DOOR_CYCLES - 1);
  state_t state, state_n;
  logic dir, dir_n, arrive_n, t_load, t_zero, above, below, further;
  logic [FLOOR_W-1:0] cur_floor_n, nf;
  logic [NUM_FLOORS-1:0] pending_n;
  logic [TW-1:0] t_val;
  elevator_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (state != IDLE),
    .zero     (t_zero)
  );
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    further = 1'b0;
    nf = (state == MOVE_UP) ? cur_floor + 1'b1 : cur_floor - 1'b1;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above = above | (pending[i] && i > int'(cur_floor));
      below = below | (pending[i] && i < int'(cur_floor));
      further = further | (pending[i] && ((state == MOVE_UP) ? i > int'(nf) : i < int'(nf)));
    end
  end
  always_comb begin
    state_n = state;
    dir_n = dir;
    cur_floor_n = cur_floor;
    pending_n = pending | req_pulse;
    arrive_n = 1'b0;
    t_load = 1'b0;
    t_val = T_TRAVEL;
    // a call for the floor the car is parked at opens the door instead of latching
    if (state == IDLE || state == DOOR) pending_n[cur_floor] = pending[cur_floor];
    case (state)
      IDLE:
        if (req_pulse[cur_floor]) begin
          state_n = DOOR;
          t_load = 1'b1;
          t_val = T_DOOR;
        end else if (above && (dir == UP || !below)) begin
          state_n = MOVE_UP;
          dir_n = UP;
          t_load = 1'b1;
        end else if (below) begin
          state_n = MOVE_DOWN;
          dir_n = DOWN;
          t_load = 1'b1;
        end
      MOVE_UP, MOVE_DOWN:
        if (t_zero) begin
          cur_floor_n = nf;
          if (pending[nf] || req_pulse[nf]) begin
            state_n = DOOR;
            pending_n[nf] = 1'b0;
            arrive_n = 1'b1;
            t_load = 1'b1;
            t_val = T_DOOR;
          end else if (further) t_load = 1'b1;
          else state_n = IDLE;
        end
      DOOR:
        if (req_pulse[cur_floor]) begin
          t_load = 1'b1;
          t_val = T_DOOR;
        end else if (t_zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= UP;
      cur_floor <= '0;
      pending <= '0;
      arrive_pulse <= 1'b0;
    end else begin
      state <= state_n;
      dir <= dir_n;
      cur_floor <= cur_floor_n;
      pending <= pending_n;
      arrive_pulse <= arrive_n;
    end
  assign moving_up = (state == MOVE_UP);
  assign moving_down = (state == MOVE_DOWN);
  assign door_open = (state == DOOR);
endmodule
